// File: rtl/bus_arbiter_mux_if.sv
// Bus arbiter/mux handshake bundle: per-source requests and data in, registered ownership and bus data out.
// Latency: carries signals only; no logic and no added delay.
// Backpressure: none; sources hold src_req for the whole transfer and watch grant to learn ownership.
// Ports (master = sources/consumers side, slave = arbiter side):
//   src_req/src_data -> arbiter; grant/grant_idx/bus_out/bus_valid/preempt <- arbiter.
interface bus_arbiter_mux_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 24
);
    localparam int IW = $clog2(NSRC);

    logic [NSRC-1:0]       src_req;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       grant;
    logic [IW-1:0]         grant_idx;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic                  preempt;

    modport master (
        output src_req, src_data,
        input  grant, grant_idx, bus_out, bus_valid, preempt
    );

    modport slave (
        input  src_req, src_data,
        output grant, grant_idx, bus_out, bus_valid, preempt
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered NSRC-way bus arbiter and mux, fixed-priority or round-robin, with ownership hold and preemption.
// Latency: request-to-grant 1 cycle; bus_out/bus_valid trail grant by 1 cycle.
// Backpressure: an owner keeps the bus while its req is high, until HOLD_MAX cycles pass with others waiting.
// Ports: clk (rising edge), clr (async active-low reset), bus (slave modport: src_req/src_data in,
//   grant/grant_idx/bus_out/bus_valid/preempt out).
module bus_arbiter_mux #(
    parameter int WIDTH    = 32,
    parameter int NSRC     = 24,
    parameter int MODE_RR  = 1,
    parameter int HOLD_MAX = 15
) (
    input  logic                clk,
    input  logic                clr,
    bus_arbiter_mux_if.slave    bus
);
    localparam int IW = $clog2(NSRC);
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HW-1:0] HMAX = HW'(HOLD_MAX);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_nxt;
    logic [NSRC-1:0] grant, grant_nxt;
    logic [IW-1:0]   grant_idx, grant_idx_nxt;
    logic [HW-1:0]   hold_cnt, hold_cnt_nxt;
    logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [WIDTH-1:0] bus_out, bus_out_nxt;
    logic            bus_valid;
    logic            preempt, preempt_nxt;

    logic [NSRC-1:0] cand;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic            owner_req;
    logic [WIDTH-1:0] owner_dat;

    // Index k steps past p, wrapping NSRC-1 -> 0.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NSRC) s = s - NSRC;
        return IW'(s);
    endfunction

    // The current owner is never a candidate: whenever we re-arbitrate while owned
    // (release or preemption) the bus must move to somebody else. In IDLE grant is
    // zero so this is simply all requesters.
    assign cand      = bus.src_req & ~grant;
    assign owner_req = |(bus.src_req & grant);

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        if (MODE_RR != 0) begin
            // Scan from farthest to nearest so the nearest hit after rr_ptr wins.
            for (int k = NSRC; k >= 1; k--) begin
                if (cand[rr_idx(rr_ptr, k)]) begin
                    pick_vld = 1'b1;
                    pick_idx = rr_idx(rr_ptr, k);
                end
            end
        end else begin
            for (int i = NSRC - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    pick_vld = 1'b1;
                    pick_idx = IW'(i);
                end
            end
        end
    end

    // grant is one-hot, so an OR of the gated slices is the owner's data.
    always_comb begin
        owner_dat = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) owner_dat = owner_dat | bus.src_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        grant_idx_nxt = grant_idx;
        hold_cnt_nxt  = hold_cnt;
        rr_ptr_nxt    = rr_ptr;
        preempt_nxt   = 1'b0;
        bus_out_nxt   = (grant != '0) ? owner_dat : bus_out;

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt     = OWN;
                    grant_nxt     = NSRC'(1) << pick_idx;
                    grant_idx_nxt = pick_idx;
                    hold_cnt_nxt  = '0;
                    rr_ptr_nxt    = pick_idx;
                end
            end
            OWN: begin
                if (owner_req) begin
                    if (pick_vld) begin
                        if (HOLD_MAX != 0 && hold_cnt == HMAX) begin
                            grant_nxt     = NSRC'(1) << pick_idx;
                            grant_idx_nxt = pick_idx;
                            hold_cnt_nxt  = '0;
                            rr_ptr_nxt    = pick_idx;
                            preempt_nxt   = 1'b1;
                        end else if (hold_cnt != HMAX) begin
                            hold_cnt_nxt = hold_cnt + HW'(1);
                        end
                    end
                end else if (pick_vld) begin
                    // Owner released with others waiting: hand over on the same edge.
                    grant_nxt     = NSRC'(1) << pick_idx;
                    grant_idx_nxt = pick_idx;
                    hold_cnt_nxt  = '0;
                    rr_ptr_nxt    = pick_idx;
                end else begin
                    state_nxt     = IDLE;
                    grant_nxt     = '0;
                    grant_idx_nxt = '0;
                    hold_cnt_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            hold_cnt  <= '0;
            rr_ptr    <= IW'(NSRC - 1);
            bus_out   <= '0;
            bus_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_idx <= grant_idx_nxt;
            hold_cnt  <= hold_cnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            bus_out   <= bus_out_nxt;
            bus_valid <= (grant != '0);
            preempt   <= preempt_nxt;
        end
    end

    assign bus.grant     = grant;
    assign bus.grant_idx = grant_idx;
    assign bus.bus_out   = bus_out;
    assign bus.bus_valid = bus_valid;
    assign bus.preempt   = preempt;
endmodule
